slug_uart_bridge: RTL and testbench
===================================

// Module: slug_uart_bridge
// PURPOSE
//  Buffered bridge between the slug CPU I/O ports (port_out/port_in) and the byte uart.
//  CPU writes/reads bytes through toggle-handshake bits; bridge queues TX bytes, paces uart
//  writes against tx_busy, drains uart rdy into an RX queue and pulses rdy_clr itself.
//  Sits in the sysclk domain between slug and uart; replaces direct port bit wiring.
// PARAMETERS
//  TX_AW        4  log2 TX FIFO depth (16 bytes)
//  RX_AW        4  log2 RX FIFO depth (16 bytes)
//  SYNC_STAGES  2  flop stages on cpu_out toggle/control bits before use (>=2)
// PORTS
//  sysclk        in   1   clock; all logic on rising edge
//  rst           in   1   reset, synchronous, active-low
//  cpu_out       in   32  slug port_out: [7:0] tx byte, [8] tx toggle, [9] rx-pop toggle, [10] ovf-clear toggle
//  cpu_in        out  32  to slug port_in (map below)
//  uart_din      out  8   byte to uart
//  uart_wr_en    out  1   one-cycle write strobe to uart
//  uart_tx_busy  in   1   uart transmitting
//  uart_dout     in   8   received byte
//  uart_rdy      in   1   uart holds a received byte
//  uart_rdy_clr  out  1   one-cycle ack clearing uart_rdy
// BEHAVIOUR
//  Reset (rst=0 at edge): FIFOs empty, sync chains and toggle history 0, FSMs idle, sticky flags 0,
//   uart_wr_en=0, uart_rdy_clr=0, uart_din=0, cpu_in=0 except bit9 per FIFO state (=0).
//   Reset mid-frame aborts state; queued bytes discarded; uart itself not reset by this block.
//  cpu_in map: [7:0] RX head byte (0 when empty), [8] rx_valid, [9] tx_full, [10] rx_ovf,
//   [11] tx_ovf, [12] tx_ack (last applied tx toggle), [13] pop_ack, [31:14] 0. All registered.
//  Toggle edge: bit [8]/[9]/[10] after SYNC_STAGES compared to stored previous value; any change = 1 event.
//   cpu_out[7:0] sampled through same stage count as bit8, so byte and toggle align.
//  TX push: tx event -> if !tx_full push byte, else drop + set tx_ovf; tx_ack<=synced bit8 either way.
//  RX pop: pop event -> if rx_valid pop head; pop_ack<=synced bit9. Pop on empty: no-op, ack still updates.
//  Clear event: rx_ovf, tx_ovf <= 0; same-cycle new overflow wins (flag stays 1).
//  TX FSM: T_IDLE -(fifo nonempty)-> T_LOAD: uart_din=head, uart_wr_en=1 one cycle, pop head
//   -> T_BUSY: wait uart_tx_busy=1 (max 4 cycles; then treat as sent, go T_IDLE)
//   -> T_DONE: wait uart_tx_busy=0 -> T_IDLE. Never pulse wr_en while tx_busy=1.
//   uart_din holds last value outside T_LOAD.
//  RX FSM: R_IDLE -(uart_rdy=1)-> R_ACK: push uart_dout (full -> drop, set rx_ovf), uart_rdy_clr=1
//   one cycle -> R_WAIT: wait uart_rdy=0 -> R_IDLE. One byte captured per rdy assertion.
//  Simultaneous push+pop on same FIFO in one cycle: both performed, count unchanged; push when
//   full with same-cycle pop is accepted. Pointers wrap modulo 2**AW; count width AW+1.
//  Latency: cpu toggle change -> byte in FIFO = SYNC_STAGES+1 cycles; FIFO nonempty -> uart_wr_en
//   = 2 cycles; uart_rdy rise -> rx_valid on cpu_in = 2 cycles.
// STRUCTURE
//  Package slug_uart_pkg: cpu_out/cpu_in bit-index localparams, tx_state_t {T_IDLE,T_LOAD,T_BUSY,
//   T_DONE}, rx_state_t {R_IDLE,R_ACK,R_WAIT}, TX_BUSY_TIMEOUT=4.
//  Sub-module byte_fifo #(AW): sync show-ahead FIFO, ports sysclk,rst,push,din,pop,dout,full,empty,count;
//   instantiated twice (TX, RX). Sync chains, toggle detect and both FSMs in this module.
// TESTING
//  Push 0x41 (bit8 0->1) with idle uart -> single uart_wr_en pulse with uart_din=0x41; tx_ack=1.
//  Push 17 bytes 0x00..0x10 while uart_tx_busy held 1 -> tx_full=1 after 16, tx_ovf=1, 0x10 dropped,
//   release busy -> 16 bytes emitted in order 0x00..0x0F.
//  uart_rdy with dout=0x5A -> one uart_rdy_clr pulse, cpu_in[8]=1, cpu_in[7:0]=0x5A; pop -> rx_valid=0.
//  17 rx bytes without pop -> rx_ovf=1, first 16 retained; clear toggle -> bits 10,11 = 0.
//  Pop and uart_rdy capture in same cycle at count=16 -> byte accepted, count stays 16, no ovf.
//  rst=0 during T_DONE with 3 queued -> next cycle all outputs at reset values, no further wr_en.

Source files
------------

// File: rtl/slug_uart_pkg.sv
// Shared definitions for the slug CPU <-> uart bridge: port bit map, FSM state types
// and the cpu_in packing helper.
package slug_uart_pkg;

  localparam int CTRL_W       = 11;
  localparam int TX_TOG_BIT   = 8;
  localparam int POP_TOG_BIT  = 9;
  localparam int CLR_TOG_BIT  = 10;

  localparam int RX_VALID_BIT = 8;
  localparam int TX_FULL_BIT  = 9;
  localparam int RX_OVF_BIT   = 10;
  localparam int TX_OVF_BIT   = 11;
  localparam int TX_ACK_BIT   = 12;
  localparam int POP_ACK_BIT  = 13;

  localparam int TX_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_BUSY, T_DONE} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} rx_state_t;

  function automatic logic [31:0] pack_cpu_in(input logic [7:0] rx_byte,
                                               input logic       rx_valid,
                                               input logic       tx_full,
                                               input logic       rx_ovf,
                                               input logic       tx_ovf,
                                               input logic       tx_ack,
                                               input logic       pop_ack);
    logic [31:0] w;
    w               = '0;
    w[7:0]          = rx_byte;
    w[RX_VALID_BIT] = rx_valid;
    w[TX_FULL_BIT]  = tx_full;
    w[RX_OVF_BIT]   = rx_ovf;
    w[TX_OVF_BIT]   = tx_ovf;
    w[TX_ACK_BIT]   = tx_ack;
    w[POP_ACK_BIT]  = pop_ack;
    return w;
  endfunction

endpackage

// File: rtl/slug_uart_bridge_if.sv
// Byte-uart side of the bridge: write strobe/data with busy, receive data/ready with clear.
interface slug_uart_bridge_if;
  logic [7:0] din;
  logic       wr_en;
  logic       tx_busy;
  logic [7:0] dout;
  logic       rdy;
  logic       rdy_clr;

  modport master (output din, wr_en, rdy_clr, input tx_busy, dout, rdy);
  modport slave  (input din, wr_en, rdy_clr, output tx_busy, dout, rdy);
endinterface

// File: rtl/slug_uart_bridge_byte_fifo.sv
// Synchronous show-ahead byte FIFO; a push while full is accepted when a pop happens the same cycle.
module byte_fifo #(
  parameter int AW = 4
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge sysclk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/slug_uart_bridge.sv
// Buffered bridge between slug port_out/port_in toggle handshakes and the byte uart:
// TX queue paced against tx_busy, RX queue filled from uart rdy with self-generated rdy_clr.
module slug_uart_bridge
  import slug_uart_pkg::*;
#(
  parameter int TX_AW       = 4,
  parameter int RX_AW       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic [31:0]         cpu_out,
  output logic [31:0]         cpu_in,
  slug_uart_bridge_if.master  uart
);

  logic [CTRL_W-1:0] sync_p [SYNC_STAGES];
  logic [CTRL_W-1:0] synced;
  logic [2:0]        tog_prev;
  logic              tx_evt, pop_evt, clr_evt;

  logic [7:0]        tx_head, rx_head;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [TX_AW:0]    tx_count;
  logic [RX_AW:0]    rx_count;
  logic              tx_pop, rx_push;
  logic              tx_ovf, rx_ovf, tx_ack, pop_ack;

  tx_state_t         tx_state, tx_next;
  rx_state_t         rx_state, rx_next;
  logic [2:0]        busy_wait;

  logic              unused_bits;
  assign unused_bits = ^{cpu_out[31:CTRL_W], tx_count, rx_count};

  // ---- stage p0..pN: cpu_out byte and toggles resynchronised together ----
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= cpu_out[CTRL_W-1:0];
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end
  assign synced = sync_p[SYNC_STAGES-1];

  always_ff @(posedge sysclk) begin
    if (!rst) tog_prev <= '0;
    else      tog_prev <= synced[CLR_TOG_BIT:TX_TOG_BIT];
  end
  assign tx_evt  = synced[TX_TOG_BIT]  ^ tog_prev[0];
  assign pop_evt = synced[POP_TOG_BIT] ^ tog_prev[1];
  assign clr_evt = synced[CLR_TOG_BIT] ^ tog_prev[2];

  // ---- queues ----
  byte_fifo #(.AW(TX_AW)) u_tx_fifo (
    .sysclk (sysclk), .rst (rst),
    .push   (tx_evt), .din (synced[7:0]), .pop (tx_pop),
    .dout   (tx_head), .full (tx_full), .empty (tx_empty), .count (tx_count)
  );

  byte_fifo #(.AW(RX_AW)) u_rx_fifo (
    .sysclk (sysclk), .rst (rst),
    .push   (rx_push), .din (uart.dout), .pop (pop_evt),
    .dout   (rx_head), .full (rx_full), .empty (rx_empty), .count (rx_count)
  );

  // A full queue only drops when no pop frees a slot in the same cycle.
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      tx_ovf  <= 1'b0;
      rx_ovf  <= 1'b0;
      tx_ack  <= 1'b0;
      pop_ack <= 1'b0;
    end else begin
      if (tx_evt && tx_full && !tx_pop) tx_ovf <= 1'b1;
      else if (clr_evt)                 tx_ovf <= 1'b0;
      if (rx_push && rx_full && !pop_evt) rx_ovf <= 1'b1;
      else if (clr_evt)                   rx_ovf <= 1'b0;
      if (tx_evt)  tx_ack  <= synced[TX_TOG_BIT];
      if (pop_evt) pop_ack <= synced[POP_TOG_BIT];
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst) cpu_in <= '0;
    else cpu_in <= pack_cpu_in(rx_empty ? 8'h00 : rx_head, !rx_empty, tx_full,
                               rx_ovf, tx_ovf, tx_ack, pop_ack);
  end

  // ---- TX FSM ----
  always_ff @(posedge sysclk) begin
    if (!rst) tx_state <= T_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (!tx_empty && !uart.tx_busy) tx_next = T_LOAD;
      T_LOAD:  tx_next = T_BUSY;
      T_BUSY:  if (uart.tx_busy) tx_next = T_DONE;
               else if (busy_wait == 3'(TX_BUSY_TIMEOUT - 1)) tx_next = T_IDLE;
      T_DONE:  if (!uart.tx_busy) tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = (tx_state == T_LOAD);
  end

  // A uart that never raises busy is treated as done after the timeout.
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      busy_wait  <= '0;
      uart.wr_en <= 1'b0;
      uart.din   <= 8'h00;
    end else begin
      busy_wait  <= (tx_state == T_BUSY) ? busy_wait + 3'd1 : 3'd0;
      uart.wr_en <= tx_pop;
      if (tx_pop) uart.din <= tx_head;
    end
  end

  // ---- RX FSM ----
  always_ff @(posedge sysclk) begin
    if (!rst) rx_state <= R_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (uart.rdy) rx_next = R_ACK;
      R_ACK:   rx_next = R_WAIT;
      R_WAIT:  if (!uart.rdy) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  // Byte is captured on the edge entering R_ACK so rx_valid shows two cycles after rdy.
  always_comb begin
    rx_push      = (rx_state == R_IDLE) && uart.rdy;
    uart.rdy_clr = (rx_state == R_ACK);
  end

endmodule

// File: tb/tb_slug_uart_bridge.sv
// Directed bench for slug_uart_bridge with a simple uart model on the interface.
module tb_slug_uart_bridge;
  logic        sysclk = 1'b0;
  logic        rst;
  logic [31:0] cpu_out;
  logic [31:0] cpu_in;
  logic        hold;
  logic [1:0]  busy_cnt = 2'd0;
  logic [7:0]  tx_log [$];
  int          clr_cnt = 0;
  int          viol    = 0;
  int          n_cmp   = 0;
  int          n_mis   = 0;

  slug_uart_bridge_if uart_bus ();

  slug_uart_bridge #(.TX_AW(4), .RX_AW(4), .SYNC_STAGES(2)) dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .cpu_out (cpu_out),
    .cpu_in  (cpu_in),
    .uart    (uart_bus)
  );

  always #5 sysclk = ~sysclk;

  assign uart_bus.tx_busy = hold | (busy_cnt != 2'd0);

  always @(posedge sysclk) begin
    if (uart_bus.wr_en) begin
      tx_log.push_back(uart_bus.din);
      busy_cnt <= 2'd3;
      if (uart_bus.tx_busy) viol <= viol + 1;
    end else if (busy_cnt != 2'd0) begin
      busy_cnt <= busy_cnt - 2'd1;
    end
    if (uart_bus.rdy_clr) clr_cnt <= clr_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic cpu_push(input logic [7:0] b);
    cpu_out[7:0] = b;
    cpu_out[8]   = ~cpu_out[8];
    cyc(5);
  endtask

  task automatic cpu_pop();
    cpu_out[9] = ~cpu_out[9];
    cyc(5);
  endtask

  task automatic uart_rx(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    uart_bus.dout = b;
    uart_bus.rdy  = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(1);
      if (uart_bus.rdy_clr) seen = 1'b1;
    end
    check_eq("rdy_clr_seen", 32'(seen), 32'd1);
    cyc(1);
    uart_bus.rdy = 1'b0;
    cyc(1);
  endtask

  task automatic wait_log(input int n, input int limit);
    for (int i = 0; i < limit && tx_log.size() < n; i++) cyc(1);
    check_eq("tx_log_count", 32'(tx_log.size()), 32'(n));
  endtask

  initial begin
    int          base;
    int          c0;
    logic [7:0]  exp_b;

    rst = 1'b0;
    cpu_out = '0;
    hold = 1'b0;
    uart_bus.dout = 8'h00;
    uart_bus.rdy  = 1'b0;
    cyc(3);
    check_eq("rst_cpu_in", cpu_in, 32'h0);
    check_eq("rst_wr_en", 32'(uart_bus.wr_en), 32'd0);
    check_eq("rst_rdy_clr", 32'(uart_bus.rdy_clr), 32'd0);
    check_eq("rst_din", 32'(uart_bus.din), 32'h0);
    rst = 1'b1;
    cyc(2);

    // single byte: exact latency toggle -> wr_en is 5 edges
    base = tx_log.size();
    cpu_out[7:0] = 8'h41;
    cpu_out[8]   = 1'b1;
    cyc(4);
    check_eq("tx_lat_early", 32'(uart_bus.wr_en), 32'd0);
    cyc(1);
    check_eq("tx_lat_wr_en", 32'(uart_bus.wr_en), 32'd1);
    check_eq("tx_lat_din", 32'(uart_bus.din), 32'h41);
    cyc(15);
    check_eq("tx1_count", 32'(tx_log.size() - base), 32'd1);
    check_eq("tx1_byte", 32'(tx_log[base]), 32'h41);
    check_eq("tx1_ack", 32'(cpu_in[12]), 32'd1);

    // 17 bytes with uart busy: 16 queued, 0x10 dropped
    hold = 1'b1;
    base = tx_log.size();
    for (int i = 0; i < 17; i++) begin
      cpu_push(8'(i));
      if (i == 14) check_eq("tx_full_at15", 32'(cpu_in[9]), 32'd0);
      if (i == 15) begin
        check_eq("tx_full_at16", 32'(cpu_in[9]), 32'd1);
        check_eq("tx_ovf_at16", 32'(cpu_in[11]), 32'd0);
      end
    end
    check_eq("tx_full_at17", 32'(cpu_in[9]), 32'd1);
    check_eq("tx_ovf_at17", 32'(cpu_in[11]), 32'd1);
    check_eq("tx_held", 32'(tx_log.size() - base), 32'd0);
    hold = 1'b0;
    wait_log(base + 16, 600);
    for (int i = 0; i < 16; i++)
      if (base + i < tx_log.size()) check_eq($sformatf("tx_order%0d", i), 32'(tx_log[base+i]), 32'(i));
    cyc(20);
    check_eq("tx_dropped", 32'(tx_log.size() - base), 32'd16);
    check_eq("tx_full_drained", 32'(cpu_in[9]), 32'd0);

    // single rx byte: rx_valid exactly 2 cycles after rdy
    c0 = clr_cnt;
    uart_bus.dout = 8'h5A;
    uart_bus.rdy  = 1'b1;
    cyc(1);
    check_eq("rx_lat_early", 32'(cpu_in[8]), 32'd0);
    check_eq("rx_rdy_clr", 32'(uart_bus.rdy_clr), 32'd1);
    cyc(1);
    check_eq("rx_lat_valid", 32'(cpu_in[8]), 32'd1);
    check_eq("rx_byte", 32'(cpu_in[7:0]), 32'h5A);
    uart_bus.rdy = 1'b0;
    cyc(4);
    check_eq("rx_clr_pulses", 32'(clr_cnt - c0), 32'd1);
    check_eq("rx_still_valid", 32'(cpu_in[8]), 32'd1);
    cpu_pop();
    check_eq("rx_popped", 32'(cpu_in[8]), 32'd0);
    check_eq("rx_pop_byte0", 32'(cpu_in[7:0]), 32'h0);
    check_eq("pop_ack", 32'(cpu_in[13]), 32'd1);
    cpu_pop();
    check_eq("pop_empty_ack", 32'(cpu_in[13]), 32'd0);
    check_eq("pop_empty_valid", 32'(cpu_in[8]), 32'd0);

    // 17 rx bytes without pop
    for (int i = 0; i < 17; i++) begin
      uart_rx(8'h80 + 8'(i));
      if (i == 15) check_eq("rx_ovf_at16", 32'(cpu_in[10]), 32'd0);
    end
    check_eq("rx_ovf_at17", 32'(cpu_in[10]), 32'd1);
    check_eq("rx_head_first", 32'(cpu_in[7:0]), 32'h80);
    cpu_out[10] = ~cpu_out[10];
    cyc(5);
    check_eq("ovf_cleared", 32'(cpu_in[11:10]), 32'd0);

    // pop and capture on the same edge while full
    cpu_out[9] = ~cpu_out[9];
    cyc(2);
    uart_rx(8'h99);
    cyc(2);
    check_eq("same_cycle_no_ovf", 32'(cpu_in[10]), 32'd0);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'h81 + 8'(i) : 8'h99;
      check_eq($sformatf("rx_order%0d", i), 32'(cpu_in[7:0]), 32'(exp_b));
      cpu_pop();
    end
    check_eq("rx_drained", 32'(cpu_in[8]), 32'd0);

    // reset while waiting in T_DONE with three bytes queued
    hold = 1'b1;
    for (int i = 0; i < 4; i++) cpu_push(8'hA0 + 8'(i));
    hold = 1'b0;
    for (int i = 0; i < 20 && !uart_bus.wr_en; i++) cyc(1);
    check_eq("rst_test_wr_en", 32'(uart_bus.wr_en), 32'd1);
    check_eq("rst_test_din", 32'(uart_bus.din), 32'hA0);
    @(posedge sysclk);
    #1 hold = 1'b1;
    cyc(3);
    base = tx_log.size();
    rst = 1'b0;
    cpu_out = '0;
    cyc(1);
    check_eq("midrst_cpu_in", cpu_in, 32'h0);
    check_eq("midrst_wr_en", 32'(uart_bus.wr_en), 32'd0);
    check_eq("midrst_rdy_clr", 32'(uart_bus.rdy_clr), 32'd0);
    check_eq("midrst_din", 32'(uart_bus.din), 32'h0);
    rst = 1'b1;
    hold = 1'b0;
    cyc(40);
    check_eq("midrst_no_wr", 32'(tx_log.size() - base), 32'd0);
    check_eq("midrst_cpu_in_after", cpu_in, 32'h0);
    check_eq("busy_write_viol", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
